// File: rtl/io_pwm_led_pkg.sv
// io_pwm_pkg: register map offsets, CTRL/STATUS bit positions and the PERIOD
// reset value shared by the PWM LED peripheral and its channel slices.
package io_pwm_pkg;

  localparam int unsigned CTRL_OFS     = 0;
  localparam int unsigned PRESCALE_OFS = 1;
  localparam int unsigned PERIOD_OFS   = 2;
  localparam int unsigned STATUS_OFS   = 3;
  localparam int unsigned DUTY_OFS     = 4;

  localparam int unsigned CTRL_EN_BIT  = 0;
  localparam int unsigned CTRL_INV_BIT = 1;
  localparam int unsigned CTRL_IRQ_BIT = 2;

  localparam int unsigned STAT_WRAP_BIT    = 0;
  localparam int unsigned STAT_SETTLED_BIT = 1;

  // PERIOD resets to all ones of the counter width, i.e. the longest period.
  function automatic logic [15:0] period_rst_val(input int unsigned cw);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < cw) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/io_pwm_led_if.sv
// CPU DMA IO bus as seen by one peripheral on the read-data daisy chain.
// The master side also drives the upstream chained read data.
interface io_pwm_led_if;

  logic        dma_io_we;
  logic [13:0] dma_io_wadr;
  logic [15:0] dma_io_wdata;
  logic [13:0] dma_io_radr;
  logic [15:0] dma_io_rdata_in;
  logic [15:0] dma_io_rdata;

  modport master (
    output dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_rdata_in,
    input  dma_io_rdata
  );

  modport slave (
    input  dma_io_we, dma_io_wadr, dma_io_wdata, dma_io_radr, dma_io_rdata_in,
    output dma_io_rdata
  );

endinterface

// File: rtl/io_pwm_chan.sv
// io_pwm_chan: one PWM channel slice. Holds the duty shadow, which only
// changes at period wraps (or on enable) so the output never glitches, and
// produces the registered, optionally inverted compare output.
// Optional macro IO_PWM_FADE_EN: the shadow steps by one toward the
// programmed duty on each wrap instead of jumping, and settled_o reports
// shadow == duty. Without it settled_o is tied low.
module io_pwm_chan #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en_i,
  input  logic          en_load_i,
  input  logic          wrap_i,
  input  logic          inv_i,
  input  logic [CW-1:0] duty_i,
  input  logic [CW-1:0] cnt_i,
  output logic          pwm_o,
  output logic          settled_o
);

`ifdef IO_PWM_FADE_EN
  localparam logic [CW-1:0] ONE = CW'(1);
`endif

  logic [CW-1:0] duty_sh_q, duty_sh_d;
  logic          pwm_q;

  // Next duty shadow: direct load on enable, cleared while disabled, updated at wrap.
  always_comb begin
    duty_sh_d = duty_sh_q;
    if (en_load_i) begin
      duty_sh_d = duty_i;
    end else if (!en_i) begin
      duty_sh_d = '0;
    end else if (wrap_i) begin
`ifdef IO_PWM_FADE_EN
      if (duty_sh_q < duty_i) begin
        duty_sh_d = duty_sh_q + ONE;
      end else if (duty_sh_q > duty_i) begin
        duty_sh_d = duty_sh_q - ONE;
      end
`else
      duty_sh_d = duty_i;
`endif
    end
  end

  // Shadow register and registered compare output.
  always_ff @(posedge clk) begin
    if (rst) begin
      duty_sh_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      duty_sh_q <= duty_sh_d;
      pwm_q     <= (cnt_i < duty_sh_q) ^ inv_i;
    end
  end

  assign pwm_o = pwm_q;

`ifdef IO_PWM_FADE_EN
  assign settled_o = (duty_sh_q == duty_i);
`else
  assign settled_o = 1'b0;
`endif

endmodule

// File: rtl/io_pwm_led.sv
// io_pwm_led: NCH-channel PWM LED/GPIO peripheral on the CPU DMA IO bus.
// Owns register decode, the shared prescaler and period counter, and the
// sticky wrap status. Reads are combinational and chain through
// dma_io_rdata_in when the read address misses this block.
// Optional macro IO_PWM_FADE_EN (see io_pwm_chan): duty fades one step per
// wrap and STATUS bit1 reports all channels settled.
module io_pwm_led
  import io_pwm_pkg::*;
#(
  parameter int          NCH      = 3,
  parameter int          CW       = 8,
  parameter logic [13:0] BASE_ADR = 14'h3000
) (
  input  logic           clk,
  input  logic           rst,
  io_pwm_led_if.slave    bus,
  output logic [NCH-1:0] pwm_out,
  output logic           wrap_irq
);

  localparam logic [13:0]   NMAP      = 14'(DUTY_OFS + NCH);
  localparam logic [CW-1:0] CNT_MAX   = '1;
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] PERIOD_RV = CW'(period_rst_val(CW));

  logic [2:0]    ctrl_q;
  logic [CW-1:0] prescale_q;
  logic [CW-1:0] period_q;
  logic          wrap_q, wrap_d;
  logic [CW-1:0] duty_q [NCH];
  logic [CW-1:0] pre_q, pre_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [13:0]   wofs, rofs;
  logic          whit, rhit;
  logic          we_ctrl, we_pre, we_per, we_stat;
  logic [NCH-1:0] we_duty;
  logic          en, en_load, tick, wrap_pulse;
  logic [NCH-1:0] settled;
  logic [15:0]   rval;

  assign wofs = bus.dma_io_wadr - BASE_ADR;
  assign rofs = bus.dma_io_radr - BASE_ADR;
  assign whit = bus.dma_io_we && (wofs < NMAP);
  assign rhit = (rofs < NMAP);

  assign we_ctrl = whit && (wofs == 14'(CTRL_OFS));
  assign we_pre  = whit && (wofs == 14'(PRESCALE_OFS));
  assign we_per  = whit && (wofs == 14'(PERIOD_OFS));
  assign we_stat = whit && (wofs == 14'(STATUS_OFS));

  // Per-channel duty write strobes.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      we_duty[i] = whit && (wofs == 14'(DUTY_OFS + i));
    end
  end

  assign en      = ctrl_q[CTRL_EN_BIT];
  assign en_load = we_ctrl && bus.dma_io_wdata[CTRL_EN_BIT] && !en;
  assign tick    = en && (pre_q == prescale_q);
  // The all-ones term covers PERIOD being lowered below the running count.
  assign wrap_pulse = tick && ((cnt_q == period_q) || (cnt_q == CNT_MAX));

  // Prescaler and period counter next state; both held at zero while disabled.
  always_comb begin
    pre_d = pre_q;
    cnt_d = cnt_q;
    if (!en) begin
      pre_d = '0;
      cnt_d = '0;
    end else if (tick) begin
      pre_d = '0;
      cnt_d = (cnt_q == period_q) ? '0 : cnt_q + ONE;
    end else begin
      pre_d = pre_q + ONE;
    end
  end

  // Sticky wrap: a wrap in the same cycle as a STATUS write keeps it set.
  always_comb begin
    wrap_d = wrap_q;
    if (wrap_pulse) begin
      wrap_d = 1'b1;
    end else if (we_stat) begin
      wrap_d = 1'b0;
    end
  end

  // Configuration registers, counters and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q     <= '0;
      prescale_q <= '0;
      period_q   <= PERIOD_RV;
      wrap_q     <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      for (int i = 0; i < NCH; i++) duty_q[i] <= '0;
    end else begin
      if (we_ctrl) ctrl_q     <= bus.dma_io_wdata[2:0];
      if (we_pre)  prescale_q <= bus.dma_io_wdata[CW-1:0];
      if (we_per)  period_q   <= bus.dma_io_wdata[CW-1:0];
      for (int i = 0; i < NCH; i++) begin
        if (we_duty[i]) duty_q[i] <= bus.dma_io_wdata[CW-1:0];
      end
      wrap_q <= wrap_d;
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    io_pwm_chan #(.CW(CW)) u_chan (
      .clk       (clk),
      .rst       (rst),
      .en_i      (en),
      .en_load_i (en_load),
      .wrap_i    (wrap_pulse),
      .inv_i     (ctrl_q[CTRL_INV_BIT]),
      .duty_i    (duty_q[g]),
      .cnt_i     (cnt_q),
      .pwm_o     (pwm_out[g]),
      .settled_o (settled[g])
    );
  end

  // Read mux: zero-extended register on hit, otherwise pass the chain through.
  always_comb begin
    rval = '0;
    if (rofs == 14'(CTRL_OFS)) begin
      rval[2:0] = ctrl_q;
    end else if (rofs == 14'(PRESCALE_OFS)) begin
      rval[CW-1:0] = prescale_q;
    end else if (rofs == 14'(PERIOD_OFS)) begin
      rval[CW-1:0] = period_q;
    end else if (rofs == 14'(STATUS_OFS)) begin
      rval[STAT_WRAP_BIT]    = wrap_q;
      rval[STAT_SETTLED_BIT] = &settled;
    end
    for (int i = 0; i < NCH; i++) begin
      if (rofs == 14'(DUTY_OFS + i)) rval[CW-1:0] = duty_q[i];
    end
  end

  assign bus.dma_io_rdata = rhit ? rval : bus.dma_io_rdata_in;
  assign wrap_irq = wrap_q && ctrl_q[CTRL_IRQ_BIT];

endmodule
